mux_stage: RTL and testbench

// - Registered NUM_IN:1 word selector with a valid/ready handshake and a 2-entry skid buffer.
// - Generalises the plain 2:1 WL-bit select to NUM_IN inputs.
// - Adds pipeline-stage behaviour: registered output, back-pressure, flush, out-of-range detect.
// - Sits between pipeline stages, e.g. the EX forwarding-operand select feeding the ALU stage register.

---
 rtl/mux_stage_pkg.sv | 14 +
 rtl/mux_stage_mux.sv | 27 ++
 rtl/mux_stage.sv | 89 ++++++++
 tb/tb_mux_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stage_pkg.sv
// Shared helpers for the mux_stage selector.
//   sel_in_range : 1 when a select index addresses a real input
//   word_base    : bit offset of word i inside a packed bus of WL-bit words
package mux_stage_pkg;

  function automatic logic sel_in_range(input int sel, input int num_in);
    return sel < num_in;
  endfunction

  function automatic int word_base(input int i, input int wl);
    return i * wl;
  endfunction

endpackage

// File: rtl/mux_stage_mux.sv
// Combinational NUM_IN:1 word selector.
//   in_bus : packed inputs, input i at in_bus[i*WL +: WL]
//   sel    : index of the input to forward
//   word   : selected word (0 when sel is out of range)
//   err    : 1 when sel >= NUM_IN
module mux_n
  import mux_stage_pkg::*;
#(
  parameter int WL     = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WL-1:0] in_bus,
  input  logic [SEL_W-1:0]     sel,
  output logic [WL-1:0]        word,
  output logic                 err
);

  always_comb begin
    word = '0;
    err  = !sel_in_range(int'(sel), NUM_IN);
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(sel) == i) word = in_bus[word_base(i, WL) +: WL];
    end
  end

endmodule

// File: rtl/mux_stage.sv
// Registered NUM_IN:1 word selector with valid/ready handshake and a skid
// register, so in_ready can be a flop while still giving full throughput.
//   clk, rst   : clock, synchronous active-high reset
//   in_bus     : packed inputs, input i at in_bus[i*WL +: WL]
//   sel        : index of the input to forward
//   in_valid   : upstream word + sel valid
//   in_ready   : stage can accept (registered, low only while the skid is full)
//   flush      : discard every held word
//   out_data   : selected word (registered)
//   out_err    : out_data came from an out-of-range sel
//   out_valid  : out_data/out_err valid
//   out_ready  : downstream accepts
module mux_stage
  import mux_stage_pkg::*;
#(
  parameter int WL     = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN*WL-1:0] in_bus,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WL-1:0]        out_data,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WL-1:0] word_p0;
  logic          err_p0;
  logic [WL-1:0] skid_data;
  logic          skid_err;
  logic          skid_valid;
  logic          accept;
  logic          main_free;

  mux_n #(
    .WL    (WL),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_bus(in_bus),
    .sel   (sel),
    .word  (word_p0),
    .err   (err_p0)
  );

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  // Main register may be overwritten when empty or handing its word off now.
  assign main_free = !out_valid || out_ready;

  // Stage boundary: selected word -> main (out_*) / skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Older skid word goes first; accept is impossible while skid is full.
        out_data   <= skid_data;
        out_err    <= skid_err;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data  <= word_p0;
        out_err   <= err_p0;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the word, in_ready drops next cycle.
      skid_data  <= word_p0;
      skid_err   <= err_p0;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_stage.sv
module tb_mux_stage;

  localparam int WL = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*WL-1:0] in_bus;
  logic [1:0]     sel;
  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic [WL-1:0]  out_data;
  logic           out_err;
  logic           out_valid;
  logic           out_ready;

  logic [3*WL-1:0] d3_in_bus;
  logic [1:0]     d3_sel;
  logic           d3_in_valid;
  logic           d3_in_ready;
  logic           d3_flush;
  logic [WL-1:0]  d3_out_data;
  logic           d3_out_err;
  logic           d3_out_valid;
  logic           d3_out_ready;

  int errors = 0;
  int checks = 0;
  logic [WL:0] q[$];

  always #5 clk = ~clk;

  mux_stage #(.WL(WL), .NUM_IN(4)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_stage #(.WL(WL), .NUM_IN(3)) dut3 (
    .clk(clk), .rst(rst), .in_bus(d3_in_bus), .sel(d3_sel), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .flush(d3_flush), .out_data(d3_out_data), .out_err(d3_out_err),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready)
  );

  // Reference selection for the 4-input instance: {err, word}.
  function automatic logic [WL:0] model(input logic [4*WL-1:0] bus, input logic [1:0] s);
    logic [WL-1:0] w;
    case (s)
      2'd0: w = bus[31:0];
      2'd1: w = bus[63:32];
      2'd2: w = bus[95:64];
      default: w = bus[127:96];
    endcase
    return {1'b0, w};
  endfunction

  // Advance one clock; scoreboard push on accept, pop on emit (no comparison here).
  task automatic step(output bit popped, output logic [WL:0] exp, output logic [WL:0] got);
    bit clr, acc, emt;
    logic [WL:0] nw;
    popped = 1'b0;
    exp = 'x;
    got = 'x;
    clr = rst || flush;
    acc = in_valid && in_ready;
    emt = out_valid && out_ready;
    nw  = model(in_bus, sel);
    if (!clr && emt) begin
      popped = 1'b1;
      got = {out_err, out_data};
      if (q.size() > 0) exp = q.pop_front();
    end
    if (!clr && acc) q.push_back(nw);
    @(posedge clk);
    #1;
    if (clr) q.delete();
  endtask

  task automatic set_lane0(input logic [WL-1:0] v);
    in_bus = '0;
    in_bus[31:0] = v;
    sel = 2'd0;
  endtask

  task automatic test_reset();
    bit p; logic [WL:0] e, g;
    rst = 1'b1; in_valid = 1'b1; in_bus = {4{32'hDEAD_BEEF}}; sel = 2'd1;
    flush = 1'b0; out_ready = 1'b0;
    d3_in_bus = '0; d3_sel = 2'd0; d3_in_valid = 1'b0; d3_flush = 1'b0; d3_out_ready = 1'b1;
    step(p, e, g);
    step(p, e, g);
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    step(p, e, g);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_select_sweep();
    bit p; logic [WL:0] e, g;
    in_bus = {32'h44, 32'h33, 32'h22, 32'h11};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step(p, e, g);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(32'h11 * (s + 1)))
        begin errors++; $display("FAIL sweep_sel%0d got=%h/v%0b exp=%h", s, out_data, out_valid, 32'h11 * (s + 1)); end
      if (p) begin
        checks++; if (g !== e) begin errors++; $display("FAIL sweep_sb got=%h exp=%h", g, e); end
      end
    end
    in_valid = 1'b0;
    step(p, e, g);
    checks++; if (!p || g !== e) begin errors++; $display("FAIL sweep_last got=%h exp=%h", g, e); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure();
    bit p; logic [WL:0] e, g;
    logic [WL-1:0] want[3];
    int n;
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC;
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_lane0(32'hA); step(p, e, g);
    set_lane0(32'hB); step(p, e, g);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    set_lane0(32'hC); step(p, e, g);
    step(p, e, g);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin errors++; $display("FAIL bp_hold got=%h exp=a", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%0b exp=0", in_ready); end
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 10 && n < 3; k++) begin
      bit acc;
      acc = in_valid && in_ready;
      step(p, e, g);
      if (acc) in_valid = 1'b0;
      if (p) begin
        checks++;
        if (g !== {1'b0, want[n]} || g !== e)
          begin errors++; $display("FAIL bp_order%0d got=%h exp=%h", n, g, want[n]); end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", n); end
    step(p, e, g);
    checks++; if (out_valid !== 1'b0 || p) begin errors++; $display("FAIL bp_dup got=%0b exp=0", out_valid); end
  endtask

  task automatic test_out_of_range();
    bit p; logic [WL:0] e, g;
    d3_in_bus = {32'h333, 32'h222, 32'h111};
    d3_out_ready = 1'b1;
    d3_in_valid = 1'b1;
    d3_sel = 2'd2; step(p, e, g);
    checks++; if (d3_out_data !== 32'h333 || d3_out_err !== 1'b0) begin errors++; $display("FAIL oor_sel2 got=%h/%0b exp=333/0", d3_out_data, d3_out_err); end
    d3_sel = 2'd3; step(p, e, g);
    checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== 32'h0 || d3_out_err !== 1'b1) begin errors++; $display("FAIL oor_sel3 got=%h/%0b exp=0/1", d3_out_data, d3_out_err); end
    d3_sel = 2'd0; step(p, e, g);
    checks++; if (d3_out_data !== 32'h111 || d3_out_err !== 1'b0) begin errors++; $display("FAIL oor_after got=%h/%0b exp=111/0", d3_out_data, d3_out_err); end
    d3_in_valid = 1'b0;
    step(p, e, g);
  endtask

  task automatic test_flush();
    bit p; logic [WL:0] e, g;
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_lane0(32'hD); step(p, e, g);
    set_lane0(32'hE); step(p, e, g);
    set_lane0(32'hF); flush = 1'b1; step(p, e, g);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b1; in_valid = 1'b1;
    set_lane0(32'h6); step(p, e, g);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h6) begin errors++; $display("FAIL flush_next got=%h exp=6", out_data); end
    step(p, e, g);
    checks++; if (!p || g !== 33'h6 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got=%h exp=6", g); end
    // Flush while an accept is legal: the new word is dropped too.
    out_ready = 1'b0; in_valid = 1'b1;
    set_lane0(32'h7); step(p, e, g);
    set_lane0(32'h8); flush = 1'b1; step(p, e, g);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_accept got=v%0b/r%0b exp=v0/r1", out_valid, in_ready); end
    out_ready = 1'b1;
    step(p, e, g);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%0b exp=0", out_valid); end
  endtask

  task automatic test_random();
    bit p; logic [WL:0] e, g;
    int k;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      sel       = 2'($urandom_range(0, 3));
      in_bus    = {$urandom, $urandom, $urandom, $urandom};
      flush     = ($urandom_range(0, 99) == 0);
      if (flush) out_ready = 1'b0;
      step(p, e, g);
      if (p) begin
        checks++;
        if (g !== e) begin errors++; $display("FAIL random_sb cycle=%0d got=%h exp=%h", i, g, e); end
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while ((out_valid || q.size() > 0) && k < 8) begin
      step(p, e, g);
      if (p) begin
        checks++;
        if (g !== e) begin errors++; $display("FAIL random_drain got=%h exp=%h", g, e); end
      end
      k++;
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL random_empty got=%0d/v%0b exp=0/v0", q.size(), out_valid); end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_back_pressure();
    test_out_of_range();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
